// File: rtl/dm_responder.sv
// Data-memory responder: 1-cycle reads, buffered writes absorbed into a FIFO that
// drains into a single-port synchronous SRAM when the port and the pipeline allow.
module dm_responder #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int WB_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          re,
  input  logic          we,
  input  logic [DW-1:0] wrt_data,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          stall,
  input  logic          flush,
  output logic          wb_empty,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = $clog2(WB_DEPTH);

  logic [AW-1:0] wb_addr_q [WB_DEPTH];
  logic [DW-1:0] wb_data_q [WB_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   cnt_q;

  logic          full, rd_req, hit, miss_rd, enq, deq;
  logic [DW-1:0] fwd_data;
  logic          rd_valid_q, miss_pend_q;
  logic [DW-1:0] rd_data_q;

  assign full     = (cnt_q == (PW+1)'(WB_DEPTH));
  assign stall    = we & full;
  assign rd_req   = re & ~we;
  assign enq      = we & ~stall;
  assign wb_empty = (cnt_q == '0);

  // Request stage: scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (((PW+1)'(i) < cnt_q) && (wb_addr_q[head_q + PW'(i)] == addr)) begin
        hit      = 1'b1;
        fwd_data = wb_data_q[head_q + PW'(i)];
      end
    end
  end

  assign miss_rd = rd_req & ~hit;
  // Without flush, drain only in request-free cycles or to free a slot for a held write.
  assign deq     = (cnt_q != '0) & ~miss_rd & (flush | stall | ~(re | we));

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (miss_rd) begin
      mem_en   = 1'b1;
      mem_addr = addr;
    end else if (deq) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wb_addr_q[head_q];
      mem_wdata = wb_data_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      wb_addr_q[tail_q] <= addr;
      wb_data_q[tail_q] <= wrt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      miss_pend_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      if (enq) tail_q <= tail_q + 1'b1;
      if (deq) head_q <= head_q + 1'b1;
      cnt_q       <= cnt_q + (PW+1)'(enq) - (PW+1)'(deq);
      rd_valid_q  <= rd_req;
      miss_pend_q <= miss_rd;
      if (rd_req && hit)    rd_data_q <= fwd_data;
      else if (miss_pend_q) rd_data_q <= mem_rdata;
    end
  end

  // Response stage: a miss returns SRAM data straight through, then it is held.
  assign rd_data  = miss_pend_q ? mem_rdata : rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Responder side of the pipeline's data-memory port. It accepts the single-cycle re/we/addr/wrt_data requests the MEM stage issues and returns read data one cycle later.
- Backing store is a single-port synchronous SRAM. Stores are absorbed into a small FIFO write buffer so the pipeline never waits on a write. The buffer drains to SRAM in idle cycles.
- Sits between the CPU MEM stage and the data SRAM. It replaces a direct DM connection.

Parameters:
- AW, 16, address width (word addresses).
- DW, 16, data width.
- WB_DEPTH, 4, write-buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- addr  in  AW  request address
- re  in  1  read request
- we  in  1  write request
- wrt_data  in  DW  write data
- rd_data  out  DW  read data, valid when rd_valid
- rd_valid  out  1  read response strobe
- stall  out  1  request not accepted this cycle; CPU must hold the request
- flush  in  1  level; drain the buffer completely (driven from hlt)
- wb_empty  out  1  buffer empty and no SRAM write in flight
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write (valid with mem_en)
- mem_addr  out  AW  SRAM address
- mem_wdata  out  DW  SRAM write data
- mem_rdata  in  DW  SRAM read data, valid the cycle after mem_en&~mem_we

Behaviour:
- Reset (async): rd_data=0, rd_valid=0, stall=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_empty=1. Head, tail and count are cleared. Buffer contents and any pending read response are discarded.
- Buffer is a circular FIFO with head/tail pointers wrapping modulo WB_DEPTH and count 0..WB_DEPTH. Each entry holds {addr, data}.
- Write (we=1, not stalled): enqueue at tail. No response.
- Stall rules:
  - stall = we & (count==WB_DEPTH), combinational.
  - In a stalled cycle the head entry drains, so the held write is accepted next cycle.
  - Reads never stall.
- Read (re=1, we=0), issued in cycle N:
  - Address compare against all valid entries. On a hit, the youngest matching entry is forwarded: rd_data is registered in N, rd_valid=1 in N+1, and no SRAM access is made.
  - On a miss: mem_en=1, mem_we=0, mem_addr=addr in N. mem_rdata is registered into rd_data with rd_valid=1 in N+1.
  - Read latency is always exactly 1 cycle. Back-to-back reads are allowed every cycle.
- re&we both high: treated as a write only. No read response.
- SRAM port priority, per cycle:
  1. Missing read.
  2. Drain of the head entry.
  3. Idle.
- Drain: mem_en=1, mem_we=1, mem_addr/mem_wdata from head. Head advances and count decrements at the clock edge.
- Simultaneous enqueue and drain: count unchanged. Enqueue into a full buffer is legal only in the same cycle the head drains, which is the stall case: the write is held, not written.
- A read that hits an entry draining in the same cycle still forwards from the buffer.
- Flush:
  - While flush=1, drains proceed whenever the SRAM port is free. Requests are still served.
  - wb_empty = (count==0). It rises the cycle after the last drain edge.
  - Flush has no effect when already empty.
- rd_valid is a single-cycle pulse per read. It is 0 in all other cycles. rd_data holds its last value otherwise.

Test Plan:
- Reset, then read addr 0x0010 with SRAM preloaded 0x1234 -> mem_en=1/mem_we=0/mem_addr=0x0010 in N; rd_data=0x1234, rd_valid=1 in N+1; wb_empty stays 1.
- Write 0x0020<=0xAAAA, then read 0x0020 on the next cycle -> forwarded 0xAAAA with rd_valid in the following cycle. The read must not drive mem_en.
- Write 0x0030<=0x1111 then 0x0030<=0x2222, read 0x0030 before drain -> returns 0x2222 (youngest wins). After flush, SRAM[0x0030]=0x2222.
- 5 consecutive writes (0x40..0x44, data 0x0..0x4) interleaved with reads every cycle so no drain occurs -> stall=1 on the 5th write only. The write is accepted the cycle after the head drains. After flush: wb_empty=1, SRAM holds all five values in order.
- Assert flush with 3 buffered writes and no requests -> 3 consecutive mem_we cycles in FIFO order; wb_empty=1 on the cycle after the third.
- Assert rst_n=0 mid-drain with 2 entries buffered -> outputs go to reset values immediately and wb_empty=1. No further SRAM writes occur after release.
